// File: rtl/home_particle_streamer_if.sv
// Cache read port and reference-data broadcast bundle between the home
// particle streamer (master) and the cache plus extractor stages (slave).
interface home_particle_streamer_if #(
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int OFFSET_WIDTH      = 23
);
   logic [PARTICLE_ID_WIDTH-1:0] rd_addr;
   logic                         rd_en;
   logic [3*OFFSET_WIDTH-1:0]    rd_data;
   logic [3*OFFSET_WIDTH-1:0]    raw_home_pos;
   logic [PARTICLE_ID_WIDTH-1:0] particle_id;
   logic [PARTICLE_ID_WIDTH-1:0] ref_id;
   logic                         phase;
   logic                         prev_phase;
   logic                         reading_particle_num;
   logic                         valid;

   modport master (
      output rd_addr, rd_en, raw_home_pos, particle_id, ref_id, phase,
             prev_phase, reading_particle_num, valid,
      input  rd_data
   );

   modport slave (
      input  rd_addr, rd_en, raw_home_pos, particle_id, ref_id, phase,
             prev_phase, reading_particle_num, valid,
      output rd_data
   );
endinterface

// File: rtl/home_particle_streamer.sv
// Streams one home cell's particle cache: count word first, then two sweeps
// (phase 0, phase 1) of particles 1..N for every reference particle.
module home_particle_streamer #(
   parameter int PARTICLE_ID_WIDTH = 7,
   parameter int OFFSET_WIDTH      = 23
) (
   input  logic clk,
   input  logic rst,
   input  logic start_i,
   input  logic stall_i,
   output logic busy_o,
   output logic done_o,
   home_particle_streamer_if.master bus
);
   localparam int PW = PARTICLE_ID_WIDTH;
   localparam int DW = 3 * OFFSET_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      REQ_NUM,
      NUM,
      STREAM,
      DRAIN,
      FINISH
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   count_q, count_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   issRef_q, issRef_d;
   logic            issPhase_q, issPhase_d;

   logic            valid_q;
   logic [PW-1:0]   particleId_q;
   logic [PW-1:0]   refId_q;
   logic            phase_q;
   logic            prevPhase_q;
   logic            readingNum_q;
   logic            done_q;
   logic            busy_q;
   logic [DW-1:0]   hold_q;

   logic [PW-1:0]   countIn;
   logic [PW-1:0]   sweepCount;
   logic            issue;
   logic            sweepEnd;
   logic            lastIssue;
   logic            showData;

   // The first read of particle 1 is issued in NUM, straight off the
   // returning count word, so the first beat lands right after the count.
   assign countIn    = bus.rd_data[PW-1:0];
   assign sweepCount = (state_q == NUM) ? countIn : count_q;
   assign issue      = ((state_q == NUM) && (countIn != '0)) ||
                       ((state_q == STREAM) && !stall_i);
   assign sweepEnd   = (ptr_q == sweepCount);
   assign lastIssue  = issue && sweepEnd && issPhase_q && (issRef_q == sweepCount);

   assign bus.rd_en   = (state_q == REQ_NUM) || issue;
   assign bus.rd_addr = issue ? ptr_q : '0;

   // Cache data is already registered at the cache; it is forwarded while a
   // beat or the count word is presented and held otherwise.
   assign showData         = valid_q || readingNum_q;
   assign bus.raw_home_pos = showData ? bus.rd_data : hold_q;

   assign bus.particle_id          = particleId_q;
   assign bus.ref_id               = refId_q;
   assign bus.phase                = phase_q;
   assign bus.prev_phase           = prevPhase_q;
   assign bus.reading_particle_num = readingNum_q;
   assign bus.valid                = valid_q;
   assign busy_o                   = busy_q;
   assign done_o                   = done_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      ptr_d      = ptr_q;
      issRef_d   = issRef_q;
      issPhase_d = issPhase_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = REQ_NUM;
               ptr_d      = PW'(1);
               issRef_d   = PW'(1);
               issPhase_d = 1'b0;
            end
         end
         REQ_NUM: state_d = NUM;
         NUM: begin
            count_d = countIn;
            // An empty cell still passes through DRAIN so done keeps the
            // same two-cycle spacing from the last issuing cycle.
            state_d = (countIn == '0) ? DRAIN : STREAM;
         end
         STREAM: begin
            if (lastIssue) begin
               state_d = DRAIN;
            end
         end
         DRAIN:   state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (issue) begin
         ptr_d = sweepEnd ? PW'(1) : ptr_q + PW'(1);
         if (sweepEnd) begin
            issPhase_d = ~issPhase_q;
            if (issPhase_q) begin
               issRef_d = issRef_q + PW'(1);
            end
         end
      end
   end

   // Beat controls are captured at issue time and presented with the data
   // one cycle later, so ref_id/phase always line up with their beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         ptr_q        <= '0;
         issRef_q     <= '0;
         issPhase_q   <= 1'b0;
         valid_q      <= 1'b0;
         particleId_q <= '0;
         refId_q      <= '0;
         phase_q      <= 1'b0;
         prevPhase_q  <= 1'b0;
         readingNum_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         hold_q       <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         ptr_q        <= ptr_d;
         issRef_q     <= issRef_d;
         issPhase_q   <= issPhase_d;
         valid_q      <= issue;
         prevPhase_q  <= phase_q;
         readingNum_q <= (state_q == REQ_NUM);
         done_q       <= (state_q == DRAIN);
         busy_q       <= (state_d != IDLE);
         if (issue) begin
            particleId_q <= ptr_q;
            refId_q      <= issRef_q;
            phase_q      <= issPhase_q;
         end
         if (showData) begin
            hold_q <= bus.rd_data;
         end
      end
   end
endmodule

// File: tb/tb_home_particle_streamer.sv
// Scoreboard bench for home_particle_streamer: expected beats are queued at
// start and compared against every valid beat the streamer presents.
module tb_home_particle_streamer;
   localparam int PW = 7;
   localparam int OW = 23;
   localparam int DW = 3 * OW;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic start = 1'b0;
   logic stall = 1'b0;
   logic busy;
   logic done;

   home_particle_streamer_if #(.PARTICLE_ID_WIDTH(PW), .OFFSET_WIDTH(OW)) bus ();

   home_particle_streamer #(.PARTICLE_ID_WIDTH(PW), .OFFSET_WIDTH(OW)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .stall_i (stall),
      .busy_o  (busy),
      .done_o  (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] id;
      logic [PW-1:0] refId;
      logic          ph;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         expQ[$];
   logic [DW-1:0] mem [0:127];

   // Particle cache model: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic          monOn      = 1'b0;
   logic          havePrev   = 1'b0;
   logic          lastPhase  = 1'b0;
   logic          prevDone   = 1'b0;
   logic [DW-1:0] expWord    = '0;
   logic [PW-1:0] lastRefExp = '0;
   int            stallAge   = 0;
   int            beatCount  = 0;
   int            doneCount  = 0;
   int            rpnCycle   = 0;
   int            firstCycle = 0;
   int            lastCycle  = 0;
   int            doneCycle  = 0;
   int            startCycle = 0;

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".raw"},   bus.raw_home_pos, DW'(0));
      checkOutput({tag, ".pid"},   DW'(bus.particle_id), DW'(0));
      checkOutput({tag, ".ref"},   DW'(bus.ref_id), DW'(0));
      checkOutput({tag, ".phase"}, DW'(bus.phase), DW'(0));
      checkOutput({tag, ".prev"},  DW'(bus.prev_phase), DW'(0));
      checkOutput({tag, ".rpn"},   DW'(bus.reading_particle_num), DW'(0));
      checkOutput({tag, ".valid"}, DW'(bus.valid), DW'(0));
      checkOutput({tag, ".busy"},  DW'(busy), DW'(0));
      checkOutput({tag, ".done"},  DW'(done), DW'(0));
      checkOutput({tag, ".rden"},  DW'(bus.rd_en), DW'(0));
      checkOutput({tag, ".rdaddr"}, DW'(bus.rd_addr), DW'(0));
   endtask

   // Fill the cache for a cell of n particles and queue the expected beats.
   task automatic loadCell(input int n);
      logic [95:0] tmp;
      beat_t       b;
      for (int i = 0; i < 128; i++) begin
         tmp    = {$urandom, $urandom, $urandom};
         mem[i] = tmp[DW-1:0];
      end
      tmp          = {$urandom, $urandom, $urandom};
      tmp[PW-1:0]  = PW'(n);
      mem[0]       = tmp[DW-1:0];
      expWord      = mem[0];
      lastRefExp   = PW'(n);
      expQ.delete();
      for (int r = 1; r <= n; r++) begin
         for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= n; k++) begin
               b.id    = PW'(k);
               b.refId = PW'(r);
               b.ph    = (p == 1);
               b.data  = mem[k];
               expQ.push_back(b);
            end
         end
      end
      beatCount = 0;
      doneCount = 0;
   endtask

   task automatic pulseStart();
      @(negedge clk);
      start      = 1'b1;
      startCycle = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic applyStimulus(input int n, input int stallAt, input int busyStartAt);
      int budget;
      loadCell(n);
      pulseStart();
      budget = 2 * n * n + 40;
      for (int i = 1; i <= budget && doneCount == 0; i++) begin
         stall = (stallAt > 0) && (i >= stallAt) && (i < stallAt + 4);
         start = (i == busyStartAt);
         @(negedge clk);
      end
      stall = 1'b0;
      start = 1'b0;
      checkOutput("timeout", DW'(doneCount != 0), DW'(1));
      repeat (2) @(negedge clk);
      checkOutput("doneOnce", DW'(doneCount), DW'(1));
      checkOutput("beatTotal", DW'(beatCount), DW'(2 * n * n));
      checkOutput("queueEmpty", DW'(expQ.size()), DW'(0));
      checkOutput("numLatency", DW'(rpnCycle - startCycle), DW'(2));
      if (n > 0) begin
         checkOutput("firstBeatLatency", DW'(firstCycle - startCycle), DW'(3));
         checkOutput("doneAfterLast", DW'(doneCycle - lastCycle), DW'(1));
         if (stallAt <= 0) begin
            checkOutput("contiguous", DW'(lastCycle - firstCycle + 1), DW'(beatCount));
         end
      end else begin
         checkOutput("emptyDoneSpacing", DW'(doneCycle - rpnCycle), DW'(2));
      end
   endtask

   // Output monitor, sampled a little after the falling edge.
   initial begin : monitor
      beat_t e;
      forever begin
         @(negedge clk);
         #1;
         if (monOn) begin
            if (havePrev) checkOutput("prevPhase", DW'(bus.prev_phase), DW'(lastPhase));
            lastPhase = bus.phase;
            havePrev  = 1'b1;
            if (stall) stallAge++;
            else stallAge = 0;
            if (stall) checkOutput("stallRdEn", DW'(bus.rd_en), DW'(0));
            if (stallAge >= 2) checkOutput("skidOnly", DW'(bus.valid), DW'(0));
            if (prevDone) checkOutput("busyAfterDone", DW'(busy), DW'(0));
            prevDone = done;
            if (bus.reading_particle_num) begin
               rpnCycle = cyc;
               checkOutput("numValid", DW'(bus.valid), DW'(0));
               checkOutput("numWord", bus.raw_home_pos, expWord);
            end
            if (bus.valid) begin
               checkOutput("extraBeat", DW'(expQ.size() != 0), DW'(1));
               if (expQ.size() != 0) begin
                  e = expQ.pop_front();
                  checkOutput("beatId", DW'(bus.particle_id), DW'(e.id));
                  checkOutput("beatRef", DW'(bus.ref_id), DW'(e.refId));
                  checkOutput("beatPhase", DW'(bus.phase), DW'(e.ph));
                  checkOutput("beatData", bus.raw_home_pos, e.data);
                  if (e.id == PW'(1) && !e.ph && e.refId > PW'(1)) begin
                     checkOutput("phaseEdge", DW'({bus.prev_phase, bus.phase}), DW'(2'b10));
                  end
               end
               if (beatCount == 0) firstCycle = cyc;
               lastCycle = cyc;
               beatCount++;
            end
            if (done) begin
               doneCount++;
               doneCycle = cyc;
               if (lastRefExp != '0) checkOutput("doneRef", DW'(bus.ref_id), DW'(lastRefExp));
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst      = 1'b1;
      havePrev = 1'b0;
      monOn    = 1'b1;

      $display("[TB] count=3, no stall");
      applyStimulus(3, 0, 0);
      $display("[TB] count=0");
      applyStimulus(0, 0, 0);
      $display("[TB] count=2 with a 4-cycle stall");
      applyStimulus(2, 5, 0);
      $display("[TB] count=1");
      applyStimulus(1, 0, 0);

      $display("[TB] reset taken mid-stream");
      loadCell(3);
      pulseStart();
      for (int i = 0; i < 20 && beatCount < 4; i++) @(negedge clk);
      checkOutput("midStreamReached", DW'(beatCount >= 4), DW'(1));
      monOn = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      checkAllZero("midReset");
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checkOutput("noDoneAfterReset", DW'(done), DW'(0));
         checkOutput("idleAfterReset", DW'(busy), DW'(0));
      end
      expQ.delete();
      havePrev = 1'b0;
      prevDone = 1'b0;
      stallAge = 0;
      monOn    = 1'b1;
      applyStimulus(2, 0, 0);

      $display("[TB] count=127 with start pulsed while busy");
      applyStimulus(127, 0, 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
